// File: rtl/bitcrusher_multimode.sv
// Bit-depth and sample-rate reducer: keeps the top K bits of each sample and can
// hold the output for F samples. BITCRUSH_DITHER_EN adds LFSR dither before truncation.
module bitcrusher_multimode #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int KB_WIDTH     = 4,
  parameter int DS_WIDTH     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SAMPLE_WIDTH-1:0] incoming_sample,
  input  logic [KB_WIDTH-1:0]     keep_bits,
  input  logic [DS_WIDTH-1:0]     downsample_factor,
  output logic [SAMPLE_WIDTH-1:0] modified_sample,
  output logic                    done,
  output logic                    busy
);

  localparam logic [KB_WIDTH-1:0] SW_KB = KB_WIDTH'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {IDLE, CRUSH, DONE} state_t;
  state_t state, state_next;

  logic [SAMPLE_WIDTH-1:0] sample_q, held, result, quant, pre_trunc, keep_mask;
  logic [KB_WIDTH-1:0]     kb_q, k_eff, drop;
  logic [DS_WIDTH-1:0]     factor_q, f_eff, cnt, cnt_inc;
  logic                    accept;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CRUSH;
      CRUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    k_eff = kb_q;
    if (kb_q == '0)        k_eff = KB_WIDTH'(1);
    else if (kb_q > SW_KB) k_eff = SW_KB;
    drop      = SW_KB - k_eff;
    keep_mask = {SAMPLE_WIDTH{1'b1}} << drop;
    f_eff     = (factor_q == '0) ? DS_WIDTH'(1) : factor_q;
    cnt_inc   = cnt + DS_WIDTH'(1);
  end

`ifdef BITCRUSH_DITHER_EN
  logic [15:0]             lfsr;
  logic [SAMPLE_WIDTH-1:0] dither;
  logic [SAMPLE_WIDTH:0]   dither_sum;

  // Galois form of x^16+x^14+x^13+x^11+1, stepped once per accepted start
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       lfsr <= 16'hACE1;
    else if (accept) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    dither     = SAMPLE_WIDTH'(lfsr) & ~keep_mask;
    dither_sum = {1'b0, sample_q} + {1'b0, dither};
    pre_trunc  = dither_sum[SAMPLE_WIDTH] ? '1 : dither_sum[SAMPLE_WIDTH-1:0];
  end
`else
  assign pre_trunc = sample_q;
`endif

  assign quant = pre_trunc & keep_mask;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q        <= '0;
      kb_q            <= '0;
      factor_q        <= '0;
      held            <= '0;
      result          <= '0;
      cnt             <= '0;
      modified_sample <= '0;
      done            <= 1'b0;
    end else begin
      if (accept) begin
        sample_q <= incoming_sample;
        kb_q     <= keep_bits;
        factor_q <= downsample_factor;
      end
      if (state == CRUSH) begin
        // counter >= F (factor shrank) is treated like a fresh hold period
        if (cnt == '0 || cnt >= f_eff) begin
          held   <= quant;
          result <= quant;
          cnt    <= (f_eff == DS_WIDTH'(1)) ? '0 : DS_WIDTH'(1);
        end else begin
          result <= held;
          cnt    <= (cnt_inc >= f_eff) ? '0 : cnt_inc;
        end
      end
      done <= (state == DONE);
      if (state == DONE) modified_sample <= result;
    end
  end

endmodule

// File: tb/tb_bitcrusher_multimode.sv
// Directed self-checking bench for bitcrusher_multimode (12-bit sample, 4-bit controls).
module tb_bitcrusher_multimode;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] incoming_sample;
  logic [3:0]  keep_bits;
  logic [3:0]  downsample_factor;
  logic [11:0] modified_sample;
  logic        done;
  logic        busy;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned done_count;

  bitcrusher_multimode #(
    .SAMPLE_WIDTH(12),
    .KB_WIDTH(4),
    .DS_WIDTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .incoming_sample(incoming_sample),
    .keep_bits(keep_bits),
    .downsample_factor(downsample_factor),
    .modified_sample(modified_sample),
    .done(done),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // start at edge k; done must be low after k and k+1, high after k+2
  task automatic txn(input string tag, input logic [11:0] s, input logic [3:0] kb,
                     input logic [3:0] ds, input logic [11:0] expected);
    incoming_sample   = s;
    keep_bits         = kb;
    downsample_factor = ds;
    start             = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_crush"}, busy, 1);
    check({tag, "_done_k0"}, done, 0);
    tick();
    check({tag, "_done_k1"}, done, 0);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_out"}, modified_sample, expected);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    incoming_sample = '0; keep_bits = '0; downsample_factor = '0;
    tick();
    tick();
    check("rst_out", modified_sample, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

`ifndef BITCRUSH_DITHER_EN
    txn("kb4", 12'hABC, 4'd4, 4'd1, 12'hA00);
    txn("kb12", 12'hABC, 4'd12, 4'd1, 12'hABC);
    txn("kb0", 12'hABC, 4'd0, 4'd1, 12'h800);
    txn("kb15", 12'hABC, 4'd15, 4'd1, 12'hABC);
    txn("kb1_ds0", 12'h7FF, 4'd1, 4'd0, 12'h000);
`else
    txn("dith_sat", 12'hFFF, 4'd4, 4'd1, 12'hF00);
    incoming_sample = 12'h0FF; keep_bits = 4'd4; downsample_factor = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("dith_0ff_done", done, 1);
    check("dith_0ff_out", (modified_sample == 12'h000) || (modified_sample == 12'h100), 1);
    txn("dith_kb12", 12'hABC, 4'd12, 4'd1, 12'hABC);
`endif

    // rate reduction, F=3, then F shrinks to 2 with counter already at 2
    do_reset();
    txn("ds_a", 12'h100, 4'd12, 4'd3, 12'h100);
    txn("ds_b", 12'h200, 4'd12, 4'd3, 12'h100);
    txn("ds_c", 12'h300, 4'd12, 4'd3, 12'h100);
    txn("ds_d", 12'h400, 4'd12, 4'd3, 12'h400);
    txn("ds_e", 12'h500, 4'd12, 4'd3, 12'h400);
    txn("shrink_load", 12'h600, 4'd12, 4'd2, 12'h600);
    txn("shrink_hold", 12'h700, 4'd12, 4'd2, 12'h600);
    txn("shrink_wrap", 12'h7F0, 4'd12, 4'd2, 12'h7F0);

    // start re-pulsed during CRUSH and DONE, inputs changed while busy
    incoming_sample = 12'h123; keep_bits = 4'd12; downsample_factor = 4'd1; start = 1'b1;
    tick();
    incoming_sample = 12'hEEE;
    tick();
    tick();
    start = 1'b0;
    check("hs_done", done, 1);
    check("hs_out", modified_sample, 12'h123);
    done_count = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_count++;
    end
    check("hs_extra_done", done_count, 0);
    check("hs_busy_after", busy, 0);

    // start held high for 9 cycles
    incoming_sample = 12'h456; start = 1'b1;
    done_count = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("hold_busy_%0d", i), busy, (i % 3 != 2) ? 1 : 0);
      if (done) done_count++;
    end
    start = 1'b0;
    check("hold_done_count", done_count, 3);
    check("hold_out", modified_sample, 12'h456);

    // reset asserted in the CRUSH cycle
    incoming_sample = 12'hFED; start = 1'b1;
    tick();
    start = 1'b0;
    check("mid_busy_crush", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", modified_sample, 0);
    tick();
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_count++;
    end
    check("mid_no_done", done_count, 0);
    check("mid_out_hold", modified_sample, 0);
    txn("post_rst", 12'h321, 4'd12, 4'd1, 12'h321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
